snake_body: RTL and testbench

Position store and motion engine for the snake, directly upstream of the collision checker. On each movement tick it advances the head one cell in the current direction, shifts every body segment one slot toward the tail, and optionally grows by one segment. It publishes the head coordinate, the full 128-entry segment arrays and the live length for the collision stage to consume.

---
 rtl/snake_pkg.sv | 16 +
 rtl/snake_next_head.sv | 45 ++++
 rtl/snake_body.sv | 117 +++++++++++
 tb/tb_snake_body.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake motion engine.
package snake_pkg;
  localparam int GRID_W  = 4;
  localparam int MAX_LEN = 128;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction
endpackage

// File: rtl/snake_next_head.sv
// Next head cell from current head and direction.
// SNAKE_WRAP_EN: wrap modulo 16 instead of flagging the edge.
module snake_next_head
  import snake_pkg::*;
(
  input  logic [GRID_W-1:0] head_x_i,
  input  logic [GRID_W-1:0] head_y_i,
  input  dir_t              dir_i,
  output logic [GRID_W-1:0] next_x_o,
  output logic [GRID_W-1:0] next_y_o,
  output logic              oob_o
);
  logic edge_hit;

  always_comb begin
    next_x_o = head_x_i;
    next_y_o = head_y_i;
    edge_hit = 1'b0;
    unique case (1'b1)
      (dir_i == UP): begin
        next_y_o = head_y_i - 1'b1;
        edge_hit = (head_y_i == '0);
      end
      (dir_i == DOWN): begin
        next_y_o = head_y_i + 1'b1;
        edge_hit = &head_y_i;
      end
      (dir_i == LEFT): begin
        next_x_o = head_x_i - 1'b1;
        edge_hit = (head_x_i == '0);
      end
      default: begin
        next_x_o = head_x_i + 1'b1;
        edge_hit = &head_x_i;
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  // 4-bit arithmetic already wraps; the edge is never a wall.
  assign oob_o = 1'b0 & edge_hit;
`else
  assign oob_o = edge_hit;
`endif
endmodule

// File: rtl/snake_body.sv
// Snake segment store and step engine feeding the collision checker.
// SNAKE_WRAP_EN selects torus wrap; otherwise edge steps are blocked.
module snake_body #(
  parameter int MAX_LEN   = 128,
  parameter int START_LEN = 3,
  parameter int START_X   = 8,
  parameter int START_Y   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_tick,
  input  logic       freeze,
  input  logic       dir_valid,
  input  logic [1:0] dir_req,
  input  logic       grow,
  output logic [3:0] head_x,
  output logic [3:0] head_y,
  output logic [3:0] x [0:MAX_LEN-1],
  output logic [3:0] y [0:MAX_LEN-1],
  output logic [7:0] snake_length,
  output logic       move_done,
  output logic       wall_hit
);
  import snake_pkg::*;

  logic [3:0] x_q [0:MAX_LEN-1];
  logic [3:0] y_q [0:MAX_LEN-1];
  logic [3:0] x_d [0:MAX_LEN-1];
  logic [3:0] y_d [0:MAX_LEN-1];
  logic [7:0] len_q, len_d;
  dir_t       cur_q, cur_d;
  dir_t       pend_q, pend_d;
  logic       grow_q, grow_d;
  logic       done_q, done_d;
  logic       wall_q, wall_d;

  dir_t       req_dir;
  dir_t       eff_dir;
  logic       req_ok;
  logic       step;
  logic       commit;
  logic       grow_eff;
  logic [3:0] nx, ny;
  logic       oob;

  // Reverse check uses cur_q so two quick turns cannot fold into the neck.
  assign req_dir  = dir_t'(dir_req);
  assign req_ok   = dir_valid && (req_dir != opposite(cur_q));
  assign eff_dir  = req_ok ? req_dir : pend_q;
  assign grow_eff = grow_q | grow;
  assign step     = move_tick & ~freeze;
  assign commit   = step & ~oob;

  snake_next_head u_next (
    .head_x_i (x_q[0]),
    .head_y_i (y_q[0]),
    .dir_i    (eff_dir),
    .next_x_o (nx),
    .next_y_o (ny),
    .oob_o    (oob)
  );

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    len_d  = len_q;
    cur_d  = cur_q;
    pend_d = eff_dir;
    grow_d = grow_eff;
    done_d = commit;
    wall_d = step & oob;
    if (commit) begin
      x_d[0] = nx;
      y_d[0] = ny;
      for (int i = 1; i < MAX_LEN; i++) begin
        x_d[i] = x_q[i-1];
        y_d[i] = y_q[i-1];
      end
      cur_d  = eff_dir;
      grow_d = 1'b0;
      if (grow_eff && (len_q != 8'(MAX_LEN)))
        len_d = 8'(len_q + 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        x_q[i] <= (i < START_LEN) ? 4'(START_X - i) : 4'(START_X);
        y_q[i] <= 4'(START_Y);
      end
      len_q  <= 8'(START_LEN);
      cur_q  <= RIGHT;
      pend_q <= RIGHT;
      grow_q <= 1'b0;
      done_q <= 1'b0;
      wall_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      len_q  <= len_d;
      cur_q  <= cur_d;
      pend_q <= pend_d;
      grow_q <= grow_d;
      done_q <= done_d;
      wall_q <= wall_d;
    end
  end

  assign head_x       = x_q[0];
  assign head_y       = y_q[0];
  assign x            = x_q;
  assign y            = y_q;
  assign snake_length = len_q;
  assign move_done    = done_q;
  assign wall_hit     = wall_q;
endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body against a queue-based snake model.
module tb_snake_body;
  localparam int ML = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       move_tick = 1'b0;
  logic       freeze = 1'b0;
  logic       dir_valid = 1'b0;
  logic [1:0] dir_req = 2'd0;
  logic       grow = 1'b0;
  logic [3:0] head_x, head_y;
  logic [3:0] x [0:ML-1];
  logic [3:0] y [0:ML-1];
  logic [7:0] snake_length;
  logic       move_done, wall_hit;

  snake_body dut (
    .clk          (clk),
    .rst          (rst),
    .move_tick    (move_tick),
    .freeze       (freeze),
    .dir_valid    (dir_valid),
    .dir_req      (dir_req),
    .grow         (grow),
    .head_x       (head_x),
    .head_y       (head_y),
    .x            (x),
    .y            (y),
    .snake_length (snake_length),
    .move_done    (move_done),
    .wall_hit     (wall_hit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ML-1:0][3:0] xs;
    logic [ML-1:0][3:0] ys;
    logic [7:0]         len;
    logic               md;
    logic               wh;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // Model: the body is a list of cells, head first.
  int mx[$];
  int my[$];
  int mlen, mcur, mpend, mgp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx.delete();
    my.delete();
    for (int i = 0; i < ML; i++) begin
      mx.push_back(i < 3 ? ((8 - i) & 15) : 8);
      my.push_back(8);
    end
    mlen = 3;
    mcur = 1;
    mpend = 1;
    mgp = 0;
  endtask

  task automatic cyc(input bit r, input bit tk, input bit fz,
                     input bit dv, input bit [1:0] dr, input bit gr);
    exp_t e;
    int eff, g, nx, ny;
    bit oob, md, wh;
    @(negedge clk);
    rst = r;
    move_tick = tk;
    freeze = fz;
    dir_valid = dv;
    dir_req = dr;
    grow = gr;
    md = 0;
    wh = 0;
    if (r) begin
      model_reset();
    end else begin
      eff = mpend;
      if (dv && int'(dr) != (mcur ^ 2)) eff = int'(dr);
      g = mgp | int'(gr);
      if (tk && !fz) begin
        nx = mx[0];
        ny = my[0];
        case (eff)
          0: ny = ny - 1;
          1: nx = nx + 1;
          2: ny = ny + 1;
          default: nx = nx - 1;
        endcase
`ifdef SNAKE_WRAP_EN
        nx = nx & 15;
        ny = ny & 15;
        oob = 0;
`else
        oob = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 15);
`endif
        if (!oob) begin
          mx.push_front(nx);
          my.push_front(ny);
          void'(mx.pop_back());
          void'(my.pop_back());
          mcur = eff;
          if (g != 0 && mlen < ML) mlen++;
          g = 0;
          md = 1;
        end else begin
          wh = 1;
        end
      end
      mpend = eff;
      mgp = g;
    end
    for (int i = 0; i < ML; i++) begin
      e.xs[i] = 4'(mx[i]);
      e.ys[i] = 4'(my[i]);
    end
    e.len = 8'(mlen);
    e.md = md;
    e.wh = wh;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 2'd0, 0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 2'd0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every post-edge DUT view with the queued expectation.
  initial begin
    exp_t e;
    int bad;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("head_x", 32'(head_x), 32'(e.xs[0]));
        chk("head_y", 32'(head_y), 32'(e.ys[0]));
        chk("snake_length", 32'(snake_length), 32'(e.len));
        chk("move_done", 32'(move_done), 32'(e.md));
        chk("wall_hit", 32'(wall_hit), 32'(e.wh));
        bad = -1;
        for (int i = ML - 1; i >= 0; i--)
          if (x[i] !== e.xs[i] || y[i] !== e.ys[i]) bad = i;
        n_chk++;
        if (bad >= 0) begin
          n_fail++;
          $display("FAIL segments[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                   bad, x[bad], y[bad], e.xs[bad], e.ys[bad]);
        end
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 2'd0, 0);
    settle();
    chk("rst_head_x", 32'(head_x), 32'd8);
    chk("rst_x2", 32'(x[2]), 32'd6);
    chk("rst_x3", 32'(x[3]), 32'd8);
    idle(2);

    tick(3);
    settle();
    chk("plan_head_x", 32'(head_x), 32'd11);
    chk("plan_x1", 32'(x[1]), 32'd10);
    chk("plan_x2", 32'(x[2]), 32'd9);
    chk("plan_len", 32'(snake_length), 32'd3);
    chk("plan_done", 32'(move_done), 32'd1);

    cyc(0, 1, 0, 1, 2'd3, 0);
    cyc(0, 0, 0, 1, 2'd0, 0);
    cyc(0, 0, 0, 1, 2'd3, 0);
    tick(1);
    settle();
    chk("turn_x", 32'(head_x), 32'd12);
    chk("turn_y", 32'(head_y), 32'd7);

    cyc(0, 0, 0, 0, 2'd0, 1);
    cyc(0, 0, 0, 0, 2'd0, 1);
    tick(1);
    settle();
    chk("grow_len", 32'(snake_length), 32'd4);
    tick(1);

    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 2'd0, 0);
    settle();
    chk("freeze_done", 32'(move_done), 32'd0);
    tick(1);

    cyc(0, 0, 0, 0, 2'd0, 1);
    cyc(1, 1, 0, 0, 2'd0, 1);
    tick(1);
    settle();
    chk("rst_nogrow_len", 32'(snake_length), 32'd3);
    chk("rst_step_x", 32'(head_x), 32'd9);

    cyc(1, 0, 0, 0, 2'd0, 0);
    tick(7);
    tick(1);
    settle();
`ifdef SNAKE_WRAP_EN
    chk("edge_x", 32'(head_x), 32'd0);
    chk("edge_wall", 32'(wall_hit), 32'd0);
`else
    chk("edge_x", 32'(head_x), 32'd15);
    chk("edge_wall", 32'(wall_hit), 32'd1);
`endif
    idle(1);
    settle();
    chk("edge_wall_drop", 32'(wall_hit), 32'd0);

    // Spin a 2x2 loop so every step commits while growing to the cap.
    cyc(1, 0, 0, 0, 2'd0, 0);
    for (int i = 0; i < 132; i++) begin
      bit [1:0] d;
      d = 2'((i + 1) & 3);
      cyc(0, 1, 0, 1, d, 1);
    end
    settle();
    chk("sat_len", 32'(snake_length), 32'd128);
    cyc(0, 1, 0, 1, 2'd1, 1);
    settle();
    chk("sat_hold", 32'(snake_length), 32'd128);

    cyc(1, 0, 0, 0, 2'd0, 0);
    for (int i = 0; i < 1500; i++) begin
      bit r, tk, fz, dv, gr;
      bit [1:0] dr;
      r  = ($urandom_range(0, 199) == 0);
      tk = ($urandom_range(0, 2) != 0);
      fz = ($urandom_range(0, 9) == 0);
      dv = ($urandom_range(0, 2) == 0);
      dr = 2'($urandom_range(0, 3));
      gr = ($urandom_range(0, 4) == 0);
      cyc(r, tk, fz, dv, dr, gr);
    end
    idle(3);
    settle();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
